// File: rtl/pipeline_mem.sv
// Memory-access stage between EXE and WB: issues loads/stores over a req/gnt/rvalid
// handshake, stalls upstream while an access is outstanding, aligns/extends load data.
module pipeline_mem (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] alu_result_e_i,
  input  logic [31:0] store_data_e_i,
  input  logic [2:0]  dmem_type_e_i,
  input  logic        dmem_read_e_i,
  input  logic        dmem_write_e_i,
  input  logic [31:0] extended_imm_e_i,
  input  logic [31:0] pc_plus4_e_i,
  input  logic        reg_write_en_e_i,
  input  logic [4:0]  rd_idx_e_i,
  input  logic [3:0]  result_src_e_i,
  input  logic        instr_illegal_e_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_stall_o,
  output logic [31:0] alu_result_m_o,
  output logic [31:0] load_data_m_o,
  output logic [31:0] extended_imm_m_o,
  output logic [31:0] pc_plus4_m_o,
  output logic        reg_write_en_m_o,
  output logic [4:0]  rd_idx_m_o,
  output logic [3:0]  result_src_m_o,
  output logic        instr_illegal_m_o,
  output logic        misaligned_m_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] sd);
    case (size[1:0])
      2'b00:   store_lanes = {4{sd[7:0]}};
      2'b01:   store_lanes = {2{sd[15:0]}};
      default: store_lanes = sd;
    endcase
  endfunction

  function automatic logic [31:0] align_load(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] word);
    logic        [31:0] shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    case (size)
      3'b000:  ext = 32'(b);
      3'b001:  ext = 32'(h);
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = word;
    endcase
    return ext;
  endfunction

  state_t state_q, state_d;
  logic   access, size_ok, addr_misaligned;
  logic   acc_illegal, acc_misaligned, acc_valid;
  logic   req, stall, completing;

  logic [31:0] alu_result_q, alu_result_d, load_data_q, load_data_d;
  logic [31:0] extended_imm_q, extended_imm_d, pc_plus4_q, pc_plus4_d;
  logic        reg_write_en_q, reg_write_en_d, instr_illegal_q, instr_illegal_d;
  logic        misaligned_q, misaligned_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic [3:0]  result_src_q, result_src_d;

  always_comb begin
    access = dmem_read_e_i | dmem_write_e_i;
    case (dmem_type_e_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
      default:                                size_ok = 1'b0;
    endcase
    case (dmem_type_e_i[1:0])
      2'b01:   addr_misaligned = alu_result_e_i[0];
      2'b10:   addr_misaligned = |alu_result_e_i[1:0];
      default: addr_misaligned = 1'b0;
    endcase
    acc_illegal    = access & ((dmem_read_e_i & dmem_write_e_i) | ~size_ok);
    acc_misaligned = access & ~acc_illegal & addr_misaligned;
    acc_valid      = access & ~acc_illegal & ~acc_misaligned;
  end

  // Handshake FSM; EXE inputs are frozen by the stall, so request fields come straight from them.
  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    stall      = 1'b0;
    completing = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_valid) begin
          req     = 1'b1;
          stall   = 1'b1;
          state_d = dmem_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          completing = 1'b1;
          state_d    = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign dmem_req_o   = req & resetn;
  assign mem_stall_o  = stall & resetn;
  assign dmem_we_o    = dmem_write_e_i;
  assign dmem_addr_o  = {alu_result_e_i[31:2], 2'b00};
  assign dmem_be_o    = byte_en(dmem_type_e_i, alu_result_e_i[1:0]);
  assign dmem_wdata_o = store_lanes(dmem_type_e_i, store_data_e_i);

  // MEM/WB register: a stalled cycle inserts an all-zero bubble.
  always_comb begin
    alu_result_d    = '0;
    load_data_d     = '0;
    extended_imm_d  = '0;
    pc_plus4_d      = '0;
    reg_write_en_d  = 1'b0;
    rd_idx_d        = '0;
    result_src_d    = '0;
    instr_illegal_d = 1'b0;
    misaligned_d    = 1'b0;
    if (!stall) begin
      alu_result_d    = alu_result_e_i;
      extended_imm_d  = extended_imm_e_i;
      pc_plus4_d      = pc_plus4_e_i;
      rd_idx_d        = rd_idx_e_i;
      result_src_d    = result_src_e_i;
      reg_write_en_d  = reg_write_en_e_i & ~acc_illegal & ~acc_misaligned;
      instr_illegal_d = instr_illegal_e_i | acc_illegal;
      misaligned_d    = acc_misaligned;
      if (completing && dmem_read_e_i)
        load_data_d = align_load(dmem_type_e_i, alu_result_e_i[1:0], dmem_rdata_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_result_q    <= '0;
      load_data_q     <= '0;
      extended_imm_q  <= '0;
      pc_plus4_q      <= '0;
      reg_write_en_q  <= 1'b0;
      rd_idx_q        <= '0;
      result_src_q    <= '0;
      instr_illegal_q <= 1'b0;
      misaligned_q    <= 1'b0;
    end else begin
      alu_result_q    <= alu_result_d;
      load_data_q     <= load_data_d;
      extended_imm_q  <= extended_imm_d;
      pc_plus4_q      <= pc_plus4_d;
      reg_write_en_q  <= reg_write_en_d;
      rd_idx_q        <= rd_idx_d;
      result_src_q    <= result_src_d;
      instr_illegal_q <= instr_illegal_d;
      misaligned_q    <= misaligned_d;
    end
  end

  assign alu_result_m_o    = alu_result_q;
  assign load_data_m_o     = load_data_q;
  assign extended_imm_m_o  = extended_imm_q;
  assign pc_plus4_m_o      = pc_plus4_q;
  assign reg_write_en_m_o  = reg_write_en_q;
  assign rd_idx_m_o        = rd_idx_q;
  assign result_src_m_o    = result_src_q;
  assign instr_illegal_m_o = instr_illegal_q;
  assign misaligned_m_o    = misaligned_q;

endmodule
